// File: rtl/alu_arbiter_if.sv
// Bundle between alu_arbiter, its two requesters and the shared combinational ALU.
// slave = arbiter side, master = requester/ALU side.
interface alu_arbiter_if #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
);
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [WIDTH-1:0]  req_a0;
  logic [WIDTH-1:0]  req_b0;
  logic [CTRL_W-1:0] req_ctrl0;
  logic [WIDTH-1:0]  req_a1;
  logic [WIDTH-1:0]  req_b1;
  logic [CTRL_W-1:0] req_ctrl1;
  logic [1:0]        resp_valid;
  logic [1:0]        resp_ready;
  logic [WIDTH-1:0]  resp_result;
  logic              resp_zero;
  logic [WIDTH-1:0]  alu_a;
  logic [WIDTH-1:0]  alu_b;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [WIDTH-1:0]  alu_out;
  logic              alu_zero;

  modport slave (
    input  req_valid, req_a0, req_b0, req_ctrl0, req_a1, req_b1, req_ctrl1,
    input  resp_ready, alu_out, alu_zero,
    output req_ready, resp_valid, resp_result, resp_zero, alu_a, alu_b, alu_ctrl
  );

  modport master (
    output req_valid, req_a0, req_b0, req_ctrl0, req_a1, req_b1, req_ctrl1,
    output resp_ready, alu_out, alu_zero,
    input  req_ready, resp_valid, resp_result, resp_zero, alu_a, alu_b, alu_ctrl
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin share of one combinational ALU between two requesters:
// accept (IDLE) -> drive ALU and capture (EXEC) -> hold response until taken (RESP).
module alu_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  alu_arbiter_if.slave    bus,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              gnt_sel;
  logic              accept;
  logic              grant;
  logic              last_grant;
  logic [1:0]        req_ready_c;
  logic [1:0]        resp_valid_c;
  logic [WIDTH-1:0]  a_p1;
  logic [WIDTH-1:0]  b_p1;
  logic [CTRL_W-1:0] ctrl_p1;
  logic [WIDTH-1:0]  result_p2;
  logic              zero_p2;

  // On a tie the requester not served last wins; a lone requester always wins.
  always_comb begin
    gnt_sel      = 1'b0;
    accept       = 1'b0;
    req_ready_c  = 2'b00;
    resp_valid_c = 2'b00;
    state_nxt    = state;
    if (&bus.req_valid) gnt_sel = ~last_grant;
    else                gnt_sel = bus.req_valid[1];
    case (state)
      IDLE: begin
        if (|bus.req_valid) begin
          accept               = 1'b1;
          req_ready_c[gnt_sel] = 1'b1;
          state_nxt            = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        resp_valid_c[grant] = 1'b1;
        if (bus.resp_ready[grant]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // ---- accept -> p1: operands sampled only on the handshake cycle ----
  // ---- p1 -> p2: ALU result captured at the end of EXEC ----
  always_ff @(posedge clk) begin
    if (reset) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      a_p1       <= '0;
      b_p1       <= '0;
      ctrl_p1    <= '0;
      result_p2  <= '0;
      zero_p2    <= 1'b0;
    end else begin
      if (accept) begin
        grant   <= gnt_sel;
        a_p1    <= gnt_sel ? bus.req_a1    : bus.req_a0;
        b_p1    <= gnt_sel ? bus.req_b1    : bus.req_b0;
        ctrl_p1 <= gnt_sel ? bus.req_ctrl1 : bus.req_ctrl0;
      end
      if (state == EXEC) begin
        result_p2 <= bus.alu_out;
        zero_p2   <= bus.alu_zero;
      end
      if (state == RESP && bus.resp_ready[grant]) last_grant <= grant;
    end
  end

  assign bus.req_ready   = req_ready_c;
  assign bus.resp_valid  = resp_valid_c;
  assign bus.resp_result = result_p2;
  assign bus.resp_zero   = zero_p2;
  assign bus.alu_a       = a_p1;
  assign bus.alu_b       = b_p1;
  assign bus.alu_ctrl    = ctrl_p1;
  assign busy            = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: accepts push hand-computed expectations,
// a separate monitor pops and compares on each response handshake.
module tb_alu_arbiter;

  typedef struct packed {
    logic        idx;
    logic [31:0] res;
    logic        zero;
    int          acc;
  } exp_t;

  logic clk;
  logic reset;
  logic busy;
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   acc_total;
  exp_t sb[$];
  int   acc_log[$];
  int   acc_cyc_log[$];
  int   hs_cyc[2];
  logic [31:0] exp_res[2];
  logic        exp_zero[2];
  logic [31:0] alu_r;

  alu_arbiter_if #(.WIDTH(32), .CTRL_W(4)) bus ();

  alu_arbiter #(.WIDTH(32), .CTRL_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU: add/sub/and/or/nor/slt/sltu, anything else gives 0.
  always_comb begin
    alu_r = 32'd0;
    case (bus.alu_ctrl)
      4'b0000: alu_r = bus.alu_a + bus.alu_b;
      4'b0001: alu_r = bus.alu_a - bus.alu_b;
      4'b0010: alu_r = bus.alu_a & bus.alu_b;
      4'b0011: alu_r = bus.alu_a | bus.alu_b;
      4'b0100: alu_r = ~(bus.alu_a | bus.alu_b);
      4'b1000: alu_r = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
      4'b1001: alu_r = {31'd0, bus.alu_a < bus.alu_b};
      default: alu_r = 32'd0;
    endcase
    bus.alu_out  = alu_r;
    bus.alu_zero = (alu_r == 32'd0);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Accept observer: pushes the expected response of whoever is granted.
  initial begin : acceptor
    exp_t e;
    logic g;
    forever begin
      @(negedge clk);
      if (!reset && bus.req_ready != 2'b00) begin
        g = bus.req_ready[1];
        chk("accept_while_idle", {31'd0, busy}, 32'd0);
        chk("ready_only_on_valid", {30'd0, bus.req_ready & ~bus.req_valid}, 32'd0);
        e.idx  = g;
        e.res  = exp_res[g];
        e.zero = exp_zero[g];
        e.acc  = cyc;
        sb.push_back(e);
        acc_log.push_back(int'(g));
        acc_cyc_log.push_back(cyc);
        acc_total++;
      end
    end
  end

  // Response monitor: latency, stability under backpressure, payload.
  initial begin : monitor
    exp_t e;
    logic idx;
    logic vprev;
    logic [31:0] prev_res;
    logic prev_zero;
    vprev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        vprev = 1'b0;
      end else if (bus.resp_valid != 2'b00) begin
        idx = bus.resp_valid[1];
        chk("resp_valid_onehot", $countones(bus.resp_valid), 32'd1);
        if (!vprev) begin
          if (sb.size() == 0) chk("unexpected_response", {30'd0, bus.resp_valid}, 32'd0);
          else                chk("latency", cyc - sb[0].acc, 32'd2);
        end else begin
          chk("held_result", bus.resp_result, prev_res);
          chk("held_zero", {31'd0, bus.resp_zero}, {31'd0, prev_zero});
        end
        if (bus.resp_ready[idx]) begin
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("resp_requester", {31'd0, idx}, {31'd0, e.idx});
            chk("resp_result", bus.resp_result, e.res);
            chk("resp_zero", {31'd0, bus.resp_zero}, {31'd0, e.zero});
          end
          hs_cyc[idx] = cyc;
          vprev = 1'b0;
        end else begin
          vprev     = 1'b1;
          prev_res  = bus.resp_result;
          prev_zero = bus.resp_zero;
        end
      end else begin
        vprev = 1'b0;
      end
    end
  end

  task automatic set_vec(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] ctrl, input logic [31:0] res, input logic z);
    if (i == 0) begin
      bus.req_a0 = a; bus.req_b0 = b; bus.req_ctrl0 = ctrl;
    end else begin
      bus.req_a1 = a; bus.req_b1 = b; bus.req_ctrl1 = ctrl;
    end
    exp_res[i]  = res;
    exp_zero[i] = z;
  endtask

  task automatic send(input int i, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] ctrl, input logic [31:0] res, input logic z,
                      input bit same);
    int start;
    int raise;
    bit ok;
    set_vec(i, a, b, ctrl, res, z);
    bus.req_valid[i] = 1'b1;
    raise = cyc;
    start = acc_total;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      if (acc_total > start) begin ok = 1'b1; break; end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    else if (same) chk("ready_same_cycle", acc_cyc_log[$], raise);
    #1 bus.req_valid[i] = 1'b0;
  endtask

  task automatic run_both(input int n);
    int start;
    bit ok;
    bus.req_valid = 2'b11;
    start = acc_total;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      if (acc_total >= start + n) begin ok = 1'b1; break; end
    end
    if (!ok) chk("contention_timeout", 32'd0, 32'd1);
    #1 bus.req_valid = 2'b00;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) begin ok = 1'b1; break; end
    end
    if (!ok) chk("drain_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base;
    int ok;
    cyc = 0; n_checks = 0; n_fail = 0; acc_total = 0;
    hs_cyc[0] = 0; hs_cyc[1] = 0;
    reset = 1'b1;
    bus.req_valid = 2'b00;
    bus.resp_ready = 2'b11;
    set_vec(0, 0, 0, 4'b0000, 0, 1'b1);
    set_vec(1, 0, 0, 4'b0000, 0, 1'b1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_req_ready", {30'd0, bus.req_ready}, 32'd0);
    chk("rst_resp_valid", {30'd0, bus.resp_valid}, 32'd0);
    chk("rst_resp_result", bus.resp_result, 32'd0);
    chk("rst_resp_zero", {31'd0, bus.resp_zero}, 32'd0);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    @(posedge clk);
    #1;

    send(0, 32'd5, 32'd7, 4'b0000, 32'd12, 1'b0, 1'b1);
    wait_idle();
    send(1, 32'h1234, 32'h1234, 4'b0001, 32'd0, 1'b1, 1'b1);
    wait_idle();

    // Contention: slt 3<1 for r0, 1<3 for r1.
    set_vec(0, 32'd3, 32'd1, 4'b1000, 32'd0, 1'b1);
    set_vec(1, 32'd1, 32'd3, 4'b1000, 32'd1, 1'b0);
    base = acc_log.size();
    run_both(4);
    wait_idle();
    if (acc_log.size() >= base + 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("rr_grant", acc_log[base + k], k % 2);
        if (k > 0) chk("rr_spacing", acc_cyc_log[base + k] - acc_cyc_log[base + k - 1], 32'd3);
      end
    end else begin
      chk("rr_accept_count", acc_log.size() - base, 32'd4);
    end

    // Backpressure on r0 while r1 waits.
    bus.resp_ready = 2'b10;
    send(0, 32'hF0, 32'h0F, 4'b0011, 32'hFF, 1'b0, 1'b0);
    set_vec(1, 32'd1, 32'd1, 4'b0000, 32'd2, 1'b0);
    bus.req_valid[1] = 1'b1;
    base = acc_total;
    ok = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (bus.resp_valid[0]) begin ok = 1; break; end
    end
    chk("bp_resp_seen", ok, 32'd1);
    repeat (4) @(posedge clk);
    #1 bus.resp_ready = 2'b11;
    ok = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      if (acc_total > base) begin ok = 1; break; end
    end
    #1 bus.req_valid[1] = 1'b0;
    chk("bp_r1_accepted", ok, 32'd1);
    if (ok == 1) begin
      chk("bp_r1_grant", acc_log[$], 32'd1);
      chk("bp_r1_after_hs", acc_cyc_log[$], hs_cyc[0] + 1);
    end
    wait_idle();

    // r0 served last, so without reset the next tie would go to r1.
    send(0, 32'hFF, 32'h0F, 4'b0010, 32'h0F, 1'b0, 1'b0);
    wait_idle();

    send(1, 32'd1, 32'd2, 4'b0000, 32'd3, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_resp_valid", {30'd0, bus.resp_valid}, 32'd0);
    chk("midrst_resp_result", bus.resp_result, 32'd0);
    chk("midrst_resp_zero", {31'd0, bus.resp_zero}, 32'd0);
    @(posedge clk);
    #1;

    // Tie after reset: r0 first with an undefined code, then r1.
    set_vec(0, 32'd9, 32'd9, 4'b0111, 32'd0, 1'b1);
    set_vec(1, 32'd2, 32'd2, 4'b0000, 32'd4, 1'b0);
    base = acc_log.size();
    run_both(2);
    wait_idle();
    if (acc_log.size() >= base + 2) begin
      chk("post_rst_tie_first", acc_log[base], 32'd0);
      chk("post_rst_tie_second", acc_log[base + 1], 32'd1);
    end else begin
      chk("post_rst_accept_count", acc_log.size() - base, 32'd2);
    end
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU (add/sub/and/or/nor/slt/sltu, 4-bit control, 32-bit operands, Zero flag) between two requesters, e.g. the integer pipeline and a branch/address unit.
- Arbitrates between the two with round-robin priority.
- Registers the operands, drives the ALU for one cycle, and captures the result and Zero flag.
- Returns the response to the winning requester over a valid/ready handshake.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU.
- CTRL_W, 4, ALU control width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  2  per-requester request valid; bit i = requester i.
- req_ready  output  2  per-requester accept; at most one bit high.
- req_a0, req_b0  input  WIDTH each  requester 0 operands.
- req_ctrl0  input  CTRL_W  requester 0 ALU control code.
- req_a1, req_b1  input  WIDTH each  requester 1 operands.
- req_ctrl1  input  CTRL_W  requester 1 ALU control code.
- resp_valid  output  2  per-requester response valid; at most one bit high.
- resp_ready  input  2  per-requester response accept.
- resp_result  output  WIDTH  captured ALU result (shared bus).
- resp_zero  output  1  captured ALU Zero flag.
- alu_a, alu_b  output  WIDTH each  operands to the ALU.
- alu_ctrl  output  CTRL_W  control code to the ALU.
- alu_out  input  WIDTH  ALU result.
- alu_zero  input  1  ALU Zero flag.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- State machine: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - If any req_valid bit is set, grant one requester.
    - Both valid: grant the requester that was NOT granted last (last_grant register).
    - One valid: grant it.
  - req_ready[grant] is asserted combinationally in the same cycle.
  - The handshake completes in that cycle: latch a, b, ctrl and the grant index; go to EXEC.
  - req_ready is 0 in every other state.
- EXEC:
  - alu_a/alu_b/alu_ctrl driven from the latched registers.
  - At the end of the cycle, capture alu_out into resp_result and alu_zero into resp_zero; go to RESP.
- RESP:
  - resp_valid[grant] = 1; resp_result/resp_zero held stable.
  - Stay in RESP until resp_ready[grant] = 1.
  - On that cycle: update last_grant = grant, deassert resp_valid next cycle, return to IDLE.
  - resp_ready on the non-granted bit is ignored.
- Latency: request accepted in cycle N -> resp_valid high in cycle N+2.
- Throughput: with no backpressure, one operation per 3 cycles.
- No new request is accepted while busy, including the cycle in which RESP completes.
- alu_a/alu_b/alu_ctrl hold the latched values outside EXEC. The ALU is combinational, so the outputs are harmless.
- Control codes are passed unmodified. Undefined codes yield the ALU default result of 0, so resp_zero = 1; no error signalled.
- Zero is taken directly from the ALU and is not recomputed.
- Reset (synchronous, any state): state = IDLE; req_ready = 0; resp_valid = 0; resp_result = 0; resp_zero = 0; operand/ctrl registers = 0; last_grant = 1 (requester 0 wins the first tie); busy = 0.
- Reset mid-operation discards the in-flight operation; no response is issued.
- A requester that deasserts req_valid before being granted is simply not served.
- Operands are sampled only at the accept cycle; later changes to the req_* inputs have no effect.

Test Plan:
- Single add: requester 0 sends a=5, b=7, ctrl=0000 -> req_ready[0] in the same cycle; 2 cycles later resp_valid[0], resp_result=12, resp_zero=0.
- Sub to zero: requester 1 sends a=0x1234, b=0x1234, ctrl=0001 -> resp_valid[1], resp_result=0, resp_zero=1.
- Round robin under contention:
  - Both requesters valid continuously, resp_ready held high.
  - Grants are 0,1,0,1 on accepts spaced every 3 cycles.
  - Results are correct per requester: r0 a=3,b=1 ctrl=1000 -> 0; r1 a=1,b=3 ctrl=1000 -> 1.
- Backpressure:
  - r0 sends ctrl=0011, a=0xF0, b=0x0F; resp_ready[0] held low for 4 cycles.
  - resp_valid[0] and resp_result=0xFF are held stable throughout; r1 is not accepted until after the response handshake completes.
- Reset mid-operation: assert reset during EXEC -> the next cycle shows IDLE, busy=0, resp_valid=0, resp_result=0; the first subsequent tie is granted to requester 0.
- Undefined ctrl=0111 with a=9, b=9 -> resp_result=0, resp_zero=1.
